// File: rtl/kernel_launch_ctrl_if.sv
// Host register port of the kernel launch controller: strobed reads/writes, read data one cycle later.
// The port has no backpressure; every strobe is accepted in the cycle it is presented.
interface kernel_launch_ctrl_if;
    logic       host_wr_en;
    logic       host_rd_en;
    logic [2:0] host_addr;
    logic [7:0] host_wr_data;
    logic [7:0] host_rd_data;

    modport master (
        output host_wr_en,
        output host_rd_en,
        output host_addr,
        output host_wr_data,
        input  host_rd_data
    );

    modport slave (
        input  host_wr_en,
        input  host_rd_en,
        input  host_addr,
        input  host_wr_data,
        output host_rd_data
    );
endinterface

// File: rtl/kernel_launch_ctrl.sv
// Kernel launch controller: host register file plus dispatcher reset/done sequencing and run-cycle counter.
// Latency: reads 1 cycle; release ARM_CYCLES cycles after start is sampled. Host port never backpressures.
module kernel_launch_ctrl #(
    parameter int ARM_CYCLES = 2,
    parameter int CYC_BITS   = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    kernel_launch_ctrl_if.slave host,
    output logic [7:0]          thread_count,
    output logic                dispatch_reset,
    input  logic                dispatch_done,
    output logic                irq
);
    localparam int AW = (ARM_CYCLES > 1) ? $clog2(ARM_CYCLES) : 1;
    localparam logic [AW-1:0] ARM_LOAD = AW'(ARM_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t              state, state_nxt;
    logic [AW-1:0]       arm_cnt, arm_cnt_nxt;
    logic [CYC_BITS-1:0] cyc, cyc_nxt;
    logic [7:0]          tc_nxt;
    logic [7:0]          rd_nxt;
    logic                done_flg, err_flg, abt_flg;
    logic                done_nxt, err_nxt, abt_nxt;
    logic                busy, wr_tc, wr_ctl, wr_sts, start_cmd, abort_cmd;
    logic [31:0]         cyc_ext;

    assign busy      = (state == ARM) || (state == RUN);
    assign wr_tc     = host.host_wr_en && (host.host_addr == 3'd0);
    assign wr_ctl    = host.host_wr_en && (host.host_addr == 3'd1);
    assign wr_sts    = host.host_wr_en && (host.host_addr == 3'd2);
    // Abort outranks start when both bits are written together.
    assign abort_cmd = wr_ctl && host.host_wr_data[1];
    assign start_cmd = wr_ctl && host.host_wr_data[0] && !host.host_wr_data[1];

    assign dispatch_reset = (state == IDLE) || (state == ARM);
    assign irq            = done_flg;
    assign cyc_ext        = 32'(cyc);

    always_comb begin
        state_nxt   = state;
        arm_cnt_nxt = arm_cnt;
        cyc_nxt     = cyc;
        tc_nxt      = thread_count;
        done_nxt    = done_flg;
        err_nxt     = err_flg;
        abt_nxt     = abt_flg;

        // W1C first so that a flag set on the same edge overrides the clear.
        if (wr_sts) begin
            if (host.host_wr_data[1]) done_nxt = 1'b0;
            if (host.host_wr_data[2]) err_nxt  = 1'b0;
            if (host.host_wr_data[3]) abt_nxt  = 1'b0;
        end

        case (state)
            IDLE, DONE: begin
                if (wr_tc) tc_nxt = host.host_wr_data;
                if (start_cmd) begin
                    if (thread_count != 8'd0) begin
                        state_nxt   = ARM;
                        arm_cnt_nxt = ARM_LOAD;
                        cyc_nxt     = '0;
                        done_nxt    = 1'b0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            ARM, RUN: begin
                if (wr_tc || start_cmd) err_nxt = 1'b1;
                if (abort_cmd) begin
                    state_nxt = IDLE;
                    abt_nxt   = 1'b1;
                end else if (state == ARM) begin
                    if (arm_cnt == '0) state_nxt = RUN;
                    else               arm_cnt_nxt = arm_cnt - 1'b1;
                end else if (dispatch_done) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end else if (cyc != '1) begin
                    cyc_nxt = cyc + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        rd_nxt = 8'd0;
        case (host.host_addr)
            3'd0:    rd_nxt = thread_count;
            3'd2:    rd_nxt = {4'd0, abt_flg, err_flg, done_flg, busy};
            3'd3:    rd_nxt = cyc_ext[7:0];
            3'd4:    rd_nxt = cyc_ext[15:8];
            3'd5:    rd_nxt = cyc_ext[23:16];
            3'd6:    rd_nxt = cyc_ext[31:24];
            default: rd_nxt = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            arm_cnt           <= '0;
            cyc               <= '0;
            thread_count      <= 8'd0;
            done_flg          <= 1'b0;
            err_flg           <= 1'b0;
            abt_flg           <= 1'b0;
            host.host_rd_data <= 8'd0;
        end else begin
            state        <= state_nxt;
            arm_cnt      <= arm_cnt_nxt;
            cyc          <= cyc_nxt;
            thread_count <= tc_nxt;
            done_flg     <= done_nxt;
            err_flg      <= err_nxt;
            abt_flg      <= abt_nxt;
            if (host.host_rd_en) host.host_rd_data <= rd_nxt;
        end
    end
endmodule
